// File: rtl/key_debounce_multi_pkg.sv
// Shared constants for the multi-channel key debouncer: 50 MHz default timings
// and the idle pin level helper.
package key_debounce_multi_pkg;

  localparam int DEB_CYCLES_20MS = 1000000;
  localparam int LONG_CYCLES_1S  = 50000000;

  // Level an unpressed pin reads: 1 for active-low buttons, 0 otherwise.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, debounce, press/release/long pulses and toggle latch; no backpressure.
// Pin edge to key_state = 2 + DEB_CYCLES clocks. KEY_AUTOREPEAT_EN adds press re-pulses after key_long.
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_20MS,
  parameter int LONG_CYCLES = LONG_CYCLES_1S,
  parameter int ACTIVE_LOW  = 1,
  parameter int CNT_W       = 32
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_toggle
);

  localparam logic             IDLE     = idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             pressed;
  logic             accept;
  logic             press_evt;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;

  assign pressed = sync2 ^ IDLE;
  assign accept  = (pressed != key_state) && (deb_cnt == DEB_LAST);

`ifdef KEY_AUTOREPEAT_EN
  localparam int               REP_CYCLES = (LONG_CYCLES / 8 > 0) ? LONG_CYCLES / 8 : 1;
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REP_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_fire;

  // Repeat phase only runs once hold_cnt has saturated, i.e. after key_long.
  assign rep_fire = key_state && (hold_cnt == LONG_MAX) && (rep_cnt == REP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rep_cnt <= '0;
    end else if (!key_state || (hold_cnt != LONG_MAX) || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign press_evt = (accept && pressed) || rep_fire;
`else
  assign press_evt = accept && pressed;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt <= '0;
    end else if ((pressed == key_state) || accept) begin
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= '0;
    end else if (!key_state) begin
      hold_cnt <= '0;
    end else if (hold_cnt != LONG_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Events are registered alongside key_state so they line up with the level change.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_toggle  <= 1'b0;
    end else begin
      if (accept) begin
        key_state <= pressed;
      end
      key_press   <= press_evt;
      key_release <= accept && !pressed;
      key_long    <= key_state && (hold_cnt == LONG_PRE);
      if (press_evt) begin
        key_toggle <= !key_toggle;
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// CH_NUM independent debounced key channels with press/release/long/toggle outputs; no backpressure.
// Latency 2 + DEB_CYCLES clocks per channel; define KEY_AUTOREPEAT_EN for held-key press repeat.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int DEB_CYCLES  = DEB_CYCLES_20MS,
  parameter int LONG_CYCLES = LONG_CYCLES_1S,
  parameter int ACTIVE_LOW  = 1,
  parameter int CNT_W       = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH_NUM-1:0] key_in,
  output logic [CH_NUM-1:0] key_state,
  output logic [CH_NUM-1:0] key_press,
  output logic [CH_NUM-1:0] key_release,
  output logic [CH_NUM-1:0] key_long,
  output logic [CH_NUM-1:0] key_toggle
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW),
      .CNT_W      (CNT_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_toggle (key_toggle[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random pin waveforms against a timestamp/history model.
// KEY_AUTOREPEAT_EN, when defined, enables the repeat expectations.
module tb_key_debounce_multi;

  localparam int CH   = 2;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int HL   = DEB + 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [CH-1:0] key_in;
  logic [CH-1:0] key_state, key_press, key_release, key_long, key_toggle;

  int checks = 0;
  int passed = 0;

  // Model: pressed-pin history (index 0 newest), edge timestamps, toggle parity.
  logic ph     [CH][HL];
  logic m_state[CH];
  logic m_press[CH];
  logic m_rel  [CH];
  logic m_long [CH];
  logic m_tog  [CH];
  int   m_rise [CH];
  int   edge_n = 0;

  key_debounce_multi #(
    .CH_NUM(CH), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1), .CNT_W(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_toggle(key_toggle)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < HL; k++) ph[c][k] = 1'b0;
      m_state[c] = 1'b0; m_press[c] = 1'b0; m_rel[c] = 1'b0;
      m_long[c]  = 1'b0; m_tog[c]   = 1'b0; m_rise[c] = 0;
    end
  endtask

  // A level is accepted once the last DEB synchronised samples (2 edges old) all disagree with it.
  task automatic model_edge();
    logic pre, all_diff;
    int   d;
    edge_n++;
    for (int c = 0; c < CH; c++) begin
      for (int k = HL - 1; k > 0; k--) ph[c][k] = ph[c][k-1];
      ph[c][0]   = ~key_in[c];
      pre        = m_state[c];
      d          = edge_n - m_rise[c];
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      m_long[c]  = pre && (d == LONG);
`ifdef KEY_AUTOREPEAT_EN
      if (pre && d > LONG && ((d - LONG) % (LONG / 8)) == 0) m_press[c] = 1'b1;
`endif
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (ph[c][2+i] == pre) all_diff = 1'b0;
      if (all_diff) begin
        m_state[c] = !pre;
        if (!pre) begin
          m_press[c] = 1'b1;
          m_rise[c]  = edge_n;
        end else begin
          m_rel[c] = 1'b1;
        end
      end
      if (m_press[c]) m_tog[c] = !m_tog[c];
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] es, ep, er, el, et;
    for (int c = 0; c < CH; c++) begin
      es[c] = m_state[c]; ep[c] = m_press[c]; er[c] = m_rel[c];
      el[c] = m_long[c];  et[c] = m_tog[c];
    end
    check("key_state", key_state, es);
    check("key_press", key_press, ep);
    check("key_release", key_release, er);
    check("key_long", key_long, el);
    check("key_toggle", key_toggle, et);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Async reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #3;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_state"}, key_state, '0);
    check({tag, "_press"}, key_press, '0);
    check({tag, "_long"}, key_long, '0);
    check({tag, "_toggle"}, key_toggle, '0);
    #2;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int lat, rise_k, long_k, n_long, n_press;
    int seg_left[CH];
    logic lvl;

    key_in    = 2'b11;
    sys_rst_n = 1'b0;
    model_reset();
    #3;
    check("rst_state", key_state, 2'b00);
    check("rst_press", key_press, 2'b00);
    check("rst_release", key_release, 2'b00);
    check("rst_long", key_long, 2'b00);
    check("rst_toggle", key_toggle, 2'b00);
    #20;
    sys_rst_n = 1'b1;
    ticks(4);

    // 1: clean press, latency 2 + DEB
    key_in = 2'b10;
    lat = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (lat < 0 && key_state[0]) lat = k;
    end
    check_int("press_latency", lat, DEB + 2);
    check("press_toggle", key_toggle, 2'b01);
    key_in = 2'b11;
    ticks(14);

    // 2: glitches shorter than DEB are rejected
    for (int r = 0; r < 3; r++) begin
      key_in = 2'b10; ticks(5);
      key_in = 2'b11; ticks(5);
    end
    ticks(6);
    check("glitch_state", key_state, 2'b00);
    check("glitch_toggle", key_toggle, 2'b01);

    // 3: long press then release
    key_in = 2'b10;
    rise_k = -1; long_k = -1; n_long = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (rise_k < 0 && key_state[0]) rise_k = k;
      if (key_long[0]) begin
        n_long++;
        long_k = k;
      end
    end
    check_int("long_count", n_long, 1);
    check_int("long_delay", long_k - rise_k, LONG);
    key_in = 2'b11;
    lat = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (lat < 0 && key_release[0]) lat = k;
    end
    check_int("release_latency", lat, DEB + 2);
    check("release_state", key_state, 2'b00);

    // 4: simultaneous press on both channels, then ch0 alone
    @(posedge sys_clk);
    model_edge();
    pulse_reset("rst4");
    key_in = 2'b00;
    lat = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (lat < 0 && key_press == 2'b11) lat = k;
    end
    check_int("both_press_latency", lat, DEB + 2);
    check("both_toggle", key_toggle, 2'b11);
    key_in = 2'b11; ticks(14);
    key_in = 2'b10; ticks(14);
    check("ch0_toggle", key_toggle, 2'b10);
    key_in = 2'b11; ticks(14);

    // 5: reset while held with hold_cnt = 20; re-accepted after release of reset
    key_in = 2'b10;
    ticks(DEB + 2 + 20);
    pulse_reset("rst5");
    lat = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (lat < 0 && key_press[0]) lat = k;
    end
    check_int("reaccept_latency", lat, DEB + 2);
    key_in = 2'b11; ticks(14);

`ifdef KEY_AUTOREPEAT_EN
    // 6: held 100 cycles -> initial press plus re-pulses every LONG/8 after key_long
    key_in = 2'b10;
    n_press = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (key_press[0]) n_press++;
    end
    key_in = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (key_press[0]) n_press++;
    end
    check_int("repeat_count", n_press, 18);
`endif

    // Random pin waveforms on both channels
    for (int c = 0; c < CH; c++) seg_left[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (seg_left[c] == 0) begin
          lvl         = 1'($urandom_range(0, 1));
          key_in[c]   = lvl;
          seg_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 50))
                                                     : int'($urandom_range(1, 12));
        end
        seg_left[c]--;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
